// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive frame decoder:
//   - frame width and bit positions of the captured 11-bit frame
//   - one-hot FSM state encoding used by uart_frame_decoder
//   - extract_byte(): pulls the data byte out of a frame, undoing line order
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int FRAME_W   = 11;
    localparam int START_BIT = 10;
    localparam int DATA_MSB  = 9;   // holds d0 (first data bit on the line)
    localparam int DATA_LSB  = 2;   // holds d7 (last data bit on the line)
    localparam int PAR_BIT   = 1;   // parity, or second stop bit without parity
    localparam int STOP_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_DECODE = 3'b010,
        ST_WRITE  = 3'b100
    } state_t;

    // The receiver shifts d0 in first, so d0 ends up at the high end of the
    // data field. byte[0] = frame[DATA_MSB] ... byte[7] = frame[DATA_LSB].
    function automatic logic [7:0] extract_byte(input logic [FRAME_W-1:0] f);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < DATA_MSB - DATA_LSB + 1; i++) begin
            b[i] = f[DATA_MSB - i];
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock first-word-fall-through FIFO holding decoded bytes.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset (empties FIFO)
//   i_push      write request; honoured when not full, or when full and a
//               pop happens in the same cycle
//   i_data      byte to write
//   i_pop       read request; ignored when empty
//   o_data      head-of-FIFO byte, forced to 0 while empty
//   o_full      FIFO holds DEPTH entries
//   o_empty     FIFO holds no entries
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // can still accept the new byte.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers alone, which keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

    // Masking while empty keeps stale or uninitialised storage off the output.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_frame_decoder.sv
// ----------------------------------------------------------------------------
// uart_frame_decoder
// Checks each captured UART frame, extracts its data byte and queues it in a
// FIFO presented to the consumer through a valid/ready handshake. Framing,
// parity and overflow events are tallied in saturating counters.
//
// Build option:
//   UART_RX_PARITY_EN  defined   : frame[1] is a parity bit (ODD_PARITY picks
//                                  odd/even), parity errors are counted.
//                      undefined : frame[1] is a second stop bit and must be 1;
//                                  perr_cnt is held at 0.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   frame        captured frame {start, d0..d7, parity/stop2, stop}
//   frame_valid  one-cycle strobe qualifying frame
//   out_data     head-of-FIFO byte (0 while empty)
//   out_valid    FIFO not empty
//   out_ready    consumer takes out_data when out_valid && out_ready
//   ferr_cnt     framing-error count
//   perr_cnt     parity-error count
//   ovf_cnt      frames lost to a full FIFO or to a busy decoder
//   clr_cnt      synchronous clear of all counters, wins over increments
// ----------------------------------------------------------------------------
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   ferr_cnt,
    output logic [CNT_W-1:0]   perr_cnt,
    output logic [CNT_W-1:0]   ovf_cnt,
    input  logic               clr_cnt
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_frame_decoder: DEPTH must be a power of two >= 2");
    end
    if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_parity
        $error("uart_frame_decoder: ODD_PARITY must be 0 or 1");
    end

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [FRAME_W-1:0] r_frame_q;
    logic               r_ferr;
    logic               r_perr;
    logic [7:0]         r_byte;

    logic [CNT_W-1:0]   r_ferr_cnt;
    logic [CNT_W-1:0]   r_ovf_cnt;

    logic               w_ferr;
    logic               w_perr;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_good;
    logic               w_push;
    logic               w_ferr_inc;
    logic               w_ovf_full;
    logic               w_ovf_busy;
    logic [1:0]         w_ovf_amt;

    // Adds amt to cnt, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       amt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(amt);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Frame checks, evaluated on the latched frame during DECODE
    // ------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    assign w_ferr = r_frame_q[START_BIT] || !r_frame_q[STOP_BIT];
    // XOR over data plus parity is 0 for even parity, 1 for odd parity.
    assign w_perr = ((^r_frame_q[DATA_MSB:DATA_LSB]) ^ r_frame_q[PAR_BIT])
                    != (ODD_PARITY != 0);
`else
    // Without parity the bit is a second stop bit and must also be 1.
    assign w_ferr = r_frame_q[START_BIT] || !r_frame_q[STOP_BIT] ||
                    !r_frame_q[PAR_BIT];
    assign w_perr = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Control: FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_frame_q <= '0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_byte    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_valid) begin
                        r_frame_q <= frame;
                        r_state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_ferr  <= w_ferr;
                    r_perr  <= w_perr;
                    r_byte  <= extract_byte(r_frame_q);
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // WRITE-cycle outcome: framing error beats parity error beats push
    // ------------------------------------------------------------------------
    assign w_pop      = out_valid && out_ready;
    assign w_ferr_inc = (r_state == ST_WRITE) && r_ferr;
    assign w_good     = (r_state == ST_WRITE) && !r_ferr && !r_perr;
    assign w_push     = w_good && (!w_full || w_pop);
    assign w_ovf_full = w_good && w_full && !w_pop;
    // The decoder only listens in IDLE; a strobe at any other time is lost.
    assign w_ovf_busy = frame_valid && (r_state != ST_IDLE);
    // Both loss sources can hit in the same cycle, so count each lost frame.
    assign w_ovf_amt  = {1'b0, w_ovf_full} + {1'b0, w_ovf_busy};

    // ------------------------------------------------------------------------
    // Status counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ferr_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else if (clr_cnt) begin
            r_ferr_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_ferr_inc)       r_ferr_cnt <= sat_add(r_ferr_cnt, 2'd1);
            if (w_ovf_amt != 2'd0) r_ovf_cnt <= sat_add(r_ovf_cnt, w_ovf_amt);
        end
    end

    assign ferr_cnt = r_ferr_cnt;
    assign ovf_cnt  = r_ovf_cnt;

`ifdef UART_RX_PARITY_EN
    logic [CNT_W-1:0] r_perr_cnt;
    logic             w_perr_inc;

    assign w_perr_inc = (r_state == ST_WRITE) && !r_ferr && r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr_cnt <= '0;
        end else if (clr_cnt) begin
            r_perr_cnt <= '0;
        end else if (w_perr_inc) begin
            r_perr_cnt <= sat_add(r_perr_cnt, 2'd1);
        end
    end

    assign perr_cnt = r_perr_cnt;
`else
    assign perr_cnt = '0;
`endif

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_byte),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed self-checking bench for uart_frame_decoder (DEPTH=8, CNT_W=8,
// even parity). Works with or without UART_RX_PARITY_EN defined.
// ----------------------------------------------------------------------------
module tb_uart_frame_decoder;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [10:0]      frame;
    logic             frame_valid;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ferr_cnt;
    logic [CNT_W-1:0] perr_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic             clr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_ferr = 0;
    int exp_perr = 0;
    int exp_ovf  = 0;

    logic [7:0] fill_d [9];

    uart_frame_decoder #(
        .DEPTH      (DEPTH),
        .ODD_PARITY (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ferr_cnt    (ferr_cnt),
        .perr_cnt    (perr_cnt),
        .ovf_cnt     (ovf_cnt),
        .clr_cnt     (clr_cnt)
    );

    // 50 MHz
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Builds a well-formed frame for data byte d: d0 goes to bit 9.
    function automatic logic [10:0] mk(input logic [7:0] d);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9 - i] = d[i];
`ifdef UART_RX_PARITY_EN
        f[1] = ^d;          // even parity
`else
        f[1] = 1'b1;        // second stop bit
`endif
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] f);
        frame       = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    // Strobe plus the DECODE and WRITE cycles; the frame is fully handled.
    task automatic send_wait(input logic [10:0] f);
        send(f);
        tick();
        tick();
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_perr"}, 32'(perr_cnt), 32'(exp_perr));
        check({tag, "_ovf"},  32'(ovf_cnt),  32'(exp_ovf));
    endtask

    initial begin
        fill_d = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'h12, 8'hFE, 8'h7F, 8'h99};

        rst         = 1'b1;
        frame       = '0;
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        clr_cnt     = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check_cnts("rst");
        rst = 1'b0;
        tick();

        // ---- good frame 0xA5, latency ----
        send(mk(8'hA5));
        tick();
        check("a5_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data",  32'(out_data),  32'hA5);
        check_cnts("a5");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a5_popped", 32'(out_valid), 32'd0);

        // ---- asymmetric byte exposes bit ordering ----
        send_wait(mk(8'h01));
        check("b01_data", 32'(out_data), 32'h01);
        send_wait(mk(8'h0E));
        check("b0e_head_unchanged", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        tick();
        check("b0e_data", 32'(out_data), 32'h0E);
        tick();
        out_ready = 1'b0;
        check("b0e_popped", 32'(out_valid), 32'd0);

        // ---- framing errors ----
        send_wait(11'b1_00000000_0_1);       // bad start bit
        exp_ferr++;
        check("ferr_start_nopush", 32'(out_valid), 32'd0);
        check("ferr_start_cnt", 32'(ferr_cnt), 32'(exp_ferr));
        send_wait(mk(8'h3C) & 11'h7FE);      // bad stop bit
        exp_ferr++;
        check("ferr_stop_nopush", 32'(out_valid), 32'd0);
        check("ferr_stop_cnt", 32'(ferr_cnt), 32'(exp_ferr));

        // ---- data 0x01 with frame[1]=0: parity error or missing stop2 ----
        send_wait(11'b0_10000000_0_1);
`ifdef UART_RX_PARITY_EN
        exp_perr++;
`else
        exp_ferr++;
`endif
        check("bit1_zero_nopush", 32'(out_valid), 32'd0);
        check_cnts("bit1_zero");
        // Same byte with frame[1]=1 is good in both builds.
        send_wait(11'b0_10000000_1_1);
        check("bit1_one_valid", 32'(out_valid), 32'd1);
        check("bit1_one_data",  32'(out_data),  32'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- fill DEPTH+1 with no consumer ----
        for (int i = 0; i < 9; i++) send_wait(mk(fill_d[i]));
        exp_ovf++;
        check_cnts("fill");
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("drain_data_%0d", i),  32'(out_data),  32'(fill_d[i]));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // ---- push while full with a pop in the WRITE cycle ----
        for (int i = 0; i < DEPTH; i++) send_wait(mk(fill_d[i]));
        frame       = mk(8'hD2);
        frame_valid = 1'b1;
        tick();                               // -> DECODE
        frame_valid = 1'b0;
        tick();                               // -> WRITE
        out_ready   = 1'b1;
        tick();                               // push and pop together
        out_ready   = 1'b0;
        check("fullpop_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        check("fullpop_head", 32'(out_data), 32'(fill_d[1]));
        out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("fullpop_data_%0d", i), 32'(out_data), 32'(fill_d[i]));
            tick();
        end
        check("fullpop_last", 32'(out_data), 32'hD2);
        tick();
        out_ready = 1'b0;
        check("fullpop_empty", 32'(out_valid), 32'd0);

        // ---- second strobe while busy is dropped ----
        frame       = mk(8'h4B);
        frame_valid = 1'b1;
        tick();                               // latched, -> DECODE
        frame       = mk(8'hB4);
        tick();                               // strobe in DECODE: lost
        frame_valid = 1'b0;
        tick();                               // WRITE: 0x4B pushed
        exp_ovf++;
        check("busy_ovf",  32'(ovf_cnt),  32'(exp_ovf));
        check("busy_data", 32'(out_data), 32'h4B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        check("busy_no_second", 32'(out_valid), 32'd0);

        // ---- counter clear ----
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_ferr = 0;
        exp_perr = 0;
        exp_ovf  = 0;
        check_cnts("clr");

        // ---- saturation: 260 framing errors stick at 255 ----
        for (int i = 0; i < 260; i++) send_wait(11'b1_00000000_0_1);
        check("sat_ferr", 32'(ferr_cnt), 32'd255);

        // ---- clear wins over increment in the same cycle ----
        send(11'b1_00000000_0_1);
        tick();                               // now in WRITE
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_prio_ferr", 32'(ferr_cnt), 32'd0);
        send_wait(11'b1_00000000_0_1);
        check("clr_then_count", 32'(ferr_cnt), 32'd1);

        // ---- asynchronous reset during DECODE ----
        send_wait(mk(8'h66));
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        send(mk(8'h77));                      // now in DECODE
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid_now", 32'(out_valid), 32'd0);
        check("arst_data_now",  32'(out_data),  32'h00);
        check("arst_ferr_now",  32'(ferr_cnt),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("arst_no_push", 32'(out_valid), 32'd0);
        check("arst_ovf",     32'(ovf_cnt),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
